// File: rtl/nco_phase_gen_pkg.sv
// nco_phase_gen_pkg
//   Shared definitions for the NCO phase generator and the sin/cos stage
//   it feeds: default datapath widths and the IDLE/RUN state encoding.
package nco_phase_gen_pkg;

  localparam int PHASE_WIDTH = 32;
  localparam int RATE_WIDTH  = 16;
  localparam int SWEEP_WIDTH = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } nco_state_t;

endpackage

// File: rtl/nco_rate_div.sv
// nco_rate_div
//   Sample-rate divider. Produces a tick every rate_i+1 clocks while
//   enable_i is high; the first enabled cycle always ticks.
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset
//   enable_i     - run; low holds the counter at 0 and suppresses ticks
//   rate_i       - sample period minus one, sampled on each tick
//   tick         - combinational tick for the current cycle
module nco_rate_div #(
  parameter int RATE_WIDTH = nco_phase_gen_pkg::RATE_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  output logic                  tick
);

  localparam logic [RATE_WIDTH-1:0] ONE = RATE_WIDTH'(1);

  logic [RATE_WIDTH-1:0] div_q;

  // Counter parked at 0 while disabled, so enabling ticks immediately.
  assign tick = enable_i && (div_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
    end else if (!enable_i) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= rate_i;
    end else begin
      div_q <= div_q - ONE;
    end
  end

endmodule

// File: rtl/nco_phase_gen.sv
// nco_phase_gen
//   Numerically controlled phase generator with phase offset and linear
//   frequency sweep. Emits one phase sample every rate_i+1 clocks.
//   Configuration is captured into a shadow register over a valid/ready
//   handshake and applied phase-continuously at the next sample boundary
//   (or on the cycle after capture while idle).
// Handshake: a transfer happens on a cycle where cfg_valid_i && cfg_ready_o;
//   cfg_ready_o stays low while the shadow holds an unapplied request, and
//   the source must hold its request until accepted.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   enable_i, rate_i     - run control and sample period minus one
//   phase_clr_i          - synchronous accumulator clear
//   cfg_*                - configuration handshake and payload
//   phase_o, valid_o     - phase sample and its one-cycle strobe
//   sweep_done_o         - pulses with the sample that ends a sweep
//   state_o              - current FSM state (debug)
module nco_phase_gen #(
  parameter int PHASE_WIDTH = nco_phase_gen_pkg::PHASE_WIDTH,
  parameter int RATE_WIDTH  = nco_phase_gen_pkg::RATE_WIDTH,
  parameter int SWEEP_WIDTH = nco_phase_gen_pkg::SWEEP_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable_i,
  input  logic [RATE_WIDTH-1:0]  rate_i,
  input  logic                   phase_clr_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [PHASE_WIDTH-1:0] cfg_freq_i,
  input  logic [PHASE_WIDTH-1:0] cfg_step_i,
  input  logic [SWEEP_WIDTH-1:0] cfg_sweep_len_i,
  input  logic [PHASE_WIDTH-1:0] cfg_offset_i,
  output logic [PHASE_WIDTH-1:0] phase_o,
  output logic                   valid_o,
  output logic                   sweep_done_o,
  output logic                   state_o
);

  import nco_phase_gen_pkg::*;

  localparam logic [SWEEP_WIDTH-1:0] SWEEP_ONE = SWEEP_WIDTH'(1);

  nco_state_t state_q, state_d;

  logic [PHASE_WIDTH-1:0] acc_q, freq_q, step_q, offset_q;
  logic [SWEEP_WIDTH-1:0] sweep_left_q;

  logic [PHASE_WIDTH-1:0] sh_freq_q, sh_step_q, sh_offset_q;
  logic [SWEEP_WIDTH-1:0] sh_len_q;
  logic                   pending_q;

  logic                   tick;
  logic                   cfg_fire;
  logic                   apply;
  logic [PHASE_WIDTH-1:0] freq_eff;
  logic [PHASE_WIDTH-1:0] offset_eff;

  nco_rate_div #(
    .RATE_WIDTH (RATE_WIDTH)
  ) u_rate_div (
    .clk      (clk),
    .resetn   (resetn),
    .enable_i (enable_i),
    .rate_i   (rate_i),
    .tick     (tick)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i)  state_d = ST_RUN;
      ST_RUN:  if (!enable_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o     = state_q;
  assign cfg_ready_o = !pending_q;
  assign cfg_fire    = cfg_valid_i && !pending_q;

  // A pending shadow is applied at the next tick, or immediately when idle.
  // An enabling cycle in IDLE also ticks, so its sample sees the new words.
  assign apply      = pending_q && (tick || (state_q == ST_IDLE));
  assign freq_eff   = apply ? sh_freq_q   : freq_q;
  assign offset_eff = apply ? sh_offset_q : offset_q;

  // Shadow register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_freq_q   <= '0;
      sh_step_q   <= '0;
      sh_offset_q <= '0;
      sh_len_q    <= '0;
      pending_q   <= 1'b0;
    end else if (cfg_fire) begin
      sh_freq_q   <= cfg_freq_i;
      sh_step_q   <= cfg_step_i;
      sh_offset_q <= cfg_offset_i;
      sh_len_q    <= cfg_sweep_len_i;
      pending_q   <= 1'b1;
    end else if (apply) begin
      pending_q   <= 1'b0;
    end
  end

  // Active frequency / sweep words. The applying tick loads fresh words
  // and does not step the sweep.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      freq_q       <= '0;
      step_q       <= '0;
      offset_q     <= '0;
      sweep_left_q <= '0;
    end else if (apply) begin
      freq_q       <= sh_freq_q;
      step_q       <= sh_step_q;
      offset_q     <= sh_offset_q;
      sweep_left_q <= sh_len_q;
    end else if (tick && (sweep_left_q != '0)) begin
      freq_q       <= freq_q + step_q;
      sweep_left_q <= sweep_left_q - SWEEP_ONE;
    end
  end

  // Accumulator: clear beats the tick update; a clear on a tick restarts
  // the phase from 0 so the next accumulator value is just freq.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
    end else if (phase_clr_i) begin
      acc_q <= tick ? freq_eff : '0;
    end else if (tick) begin
      acc_q <= acc_q + freq_eff;
    end
  end

  // Output sample registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_o      <= '0;
      valid_o      <= 1'b0;
      sweep_done_o <= 1'b0;
    end else begin
      valid_o      <= tick;
      sweep_done_o <= tick && !apply && (sweep_left_q == SWEEP_ONE);
      if (tick) begin
        phase_o <= phase_clr_i ? offset_eff : (acc_q + offset_eff);
      end
    end
  end

endmodule
